// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and the owner tag.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of cycles the loader has been kept waiting; o_sat flags
// that the loader has earned priority over the CPU.
module arb_wait_counter #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  logic [WAIT_W-1:0] r_cnt;

  assign o_sat = (r_cnt >= WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && !o_sat)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: one access at a time,
// MEM_LAT busy cycles, then a one-cycle ack to whichever side owns the port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_hold,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        r_state, w_state_nxt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata, r_ldr_rdata;
  logic [LAT_W-1:0]  r_lat_cnt;

  logic w_wait_sat, w_grant_ldr, w_grant_cpu, w_grant, w_last, w_ldr_active;

  // Loader wins on burst lock, starvation, or an idle CPU; ldr_hold also
  // keeps the CPU off the port even between loader requests.
  assign w_grant_ldr = (r_state == IDLE) && ldr_req &&
                       (ldr_hold || w_wait_sat || !cpu_req);
  assign w_grant_cpu = (r_state == IDLE) && !w_grant_ldr && cpu_req && !ldr_hold;
  assign w_grant     = w_grant_ldr | w_grant_cpu;
  assign w_last      = (r_state == BUSY) && (r_lat_cnt == LAT_W'(MEM_LAT - 1));
  assign w_ldr_active = (r_state != IDLE) && (r_owner == OWN_LDR);

  arb_wait_counter #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .i_inc(ldr_req && !w_ldr_active),
    .i_clr(!ldr_req || w_grant_ldr),
    .o_sat(w_wait_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    cpu_ack     = 1'b0;
    ldr_ack     = 1'b0;
    case (r_state)
      IDLE: if (w_grant) w_state_nxt = BUSY;
      BUSY: begin
        // Only the first busy cycle writes, so a write lands exactly once.
        mem_we = r_we && (r_lat_cnt == '0);
        if (w_last) w_state_nxt = ACK;
      end
      ACK: begin
        cpu_ack     = (r_owner == OWN_CPU);
        ldr_ack     = (r_owner == OWN_LDR);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lat_cnt   <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_grant_ldr ? OWN_LDR : OWN_CPU;
        r_we      <= w_grant_ldr ? ldr_we : cpu_we;
        r_addr    <= w_grant_ldr ? ldr_addr : cpu_addr;
        r_wdata   <= w_grant_ldr ? ldr_wdata : cpu_wdata;
        r_lat_cnt <= '0;
      end else if ((r_state == BUSY) && !w_last) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end
      if (w_last && !r_we) begin
        if (r_owner == OWN_LDR) r_ldr_rdata <= mem_rdata;
        else                    r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a timer-based transaction
// model of the port, plus a few directed scenarios including mid-access reset.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int MW  = 3;
  localparam int WW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ldr_req, ldr_we, ldr_hold, ldr_ack;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW), .WAIT_W(WW)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_hold(ldr_hold), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: m_cnt counts down the cycles left in the current access
  // (LAT busy cycles, then one ack cycle); 0 means the port is free.
  int            m_cnt, m_wait;
  bit            m_own;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_exp;
  bit            s_cack, s_lack;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wait = 0; m_own = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_exp = '0;
    s_cack = 0; s_lack = 0;
  endtask

  task automatic check_cycle();
    bit first, ack, e_c, e_l;
    first = (m_cnt == LAT + 1);
    ack   = (m_cnt == 1);
    e_c   = ack && !m_own;
    e_l   = ack && m_own;
    chk("cpu_ack",   64'(cpu_ack),   64'(e_c));
    chk("ldr_ack",   64'(ldr_ack),   64'(e_l));
    chk("mem_we",    64'(mem_we),    64'(first && m_we));
    chk("mem_addr",  64'(mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !e_c));
    if (e_c && !m_we) chk("cpu_rdata", 64'(cpu_rdata), 64'(m_exp));
    if (e_l && !m_we) chk("ldr_rdata", 64'(ldr_rdata), 64'(m_exp));
    s_cack = e_c;
    s_lack = e_l;
    if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
  endtask

  task automatic model_step();
    bit gl, gc, ldr_active;
    gl = 0; gc = 0;
    ldr_active = (m_cnt > 0) && m_own;
    if (m_cnt == 0) begin
      if (ldr_req && (ldr_hold || m_wait >= MW || !cpu_req)) gl = 1;
      else if (cpu_req && !ldr_hold) gc = 1;
    end
    if (!ldr_req || gl)   m_wait = 0;
    else if (!ldr_active) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
    if (m_cnt > 0) m_cnt--;
    if (gl || gc) begin
      m_cnt   = LAT + 1;
      m_own   = gl;
      m_we    = gl ? ldr_we : cpu_we;
      m_addr  = gl ? ldr_addr : cpu_addr;
      m_wdata = gl ? ldr_wdata : cpu_wdata;
      m_exp   = mem[m_addr[7:2]];
    end
  endtask

  // Requesters hold a request until acked, then drop it or issue the next.
  task automatic drive(input int pc, input int pl, input int ph);
    if (!cpu_req || s_cack) begin
      cpu_req = ($urandom_range(99) < pc);
      if (cpu_req) begin
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = AW'($urandom_range(63)) << 2;
        cpu_wdata = $urandom;
      end
    end
    if (!ldr_req || s_lack) begin
      ldr_req = ($urandom_range(99) < pl);
      if (ldr_req) begin
        ldr_we    = 1'($urandom_range(1));
        ldr_addr  = AW'($urandom_range(63)) << 2;
        ldr_wdata = $urandom;
      end
    end
    if ($urandom_range(99) < ph) ldr_hold = ~ldr_hold;
  endtask

  task automatic run(input int n, input int pc, input int pl, input int ph);
    repeat (n) begin
      drive(pc, pl, ph);
      @(negedge clk);
      check_cycle();
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[16] = 32'hDEADBEEF;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_hold = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack",   64'(cpu_ack),   64'(0));
    chk("rst_ldr_ack",   64'(ldr_ack),   64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_ldr_rdata", 64'(ldr_rdata), 64'(0));
    chk("rst_cpu_stall", 64'(cpu_stall), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // CPU read of 0x40
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    run(6, 0, 0, 0);
    chk("t1_rdata", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);

    // simultaneous CPU read and loader read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h48;
    run(12, 0, 0, 0);

    // loader write 0x100
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h100; ldr_wdata = 32'h12345678;
    run(6, 0, 0, 0);
    chk("t4_mem", 64'(mem[0]), 64'h0000_0000_1234_5678);

    // burst lock: CPU must not get the port while ldr_hold is high
    ldr_hold = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    run(30, 0, 60, 0);
    ldr_hold = 0;
    run(20, 0, 0, 0);

    run(1500, 50, 40, 0);   // mixed traffic
    run(1500, 100, 30, 0);  // CPU back-to-back, loader relies on starvation override
    run(1500, 70, 50, 5);   // burst lock toggling

    // reset in the first busy cycle of a CPU write
    ldr_hold = 0;
    run(16, 0, 0, 0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'hA5A5_5A5A;
    run(1, 0, 0, 0);
    chk("t6_we_pre", 64'(mem_we), 64'(1));
    reset = 1'b1;
    #1;
    chk("t6_we_rst",  64'(mem_we),  64'(0));
    chk("t6_ack_rst", 64'(cpu_ack), 64'(0));
    cpu_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_ack_hold", 64'(cpu_ack),  64'(0));
    chk("t6_addr",     64'(mem_addr), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    run(400, 60, 50, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
